// File: rtl/cga_vram_arbiter_if.sv
// Bus bundle for cga_vram_arbiter: ISA memory side, sequencer slot, video fetch address and VRAM port.
interface cga_vram_arbiter_if;
  logic [19:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_out_mem;
  logic        bus_dir_mem;
  logic        bus_rdy;
  logic        isa_op_enable;
  logic [14:0] vid_a;
  logic [18:0] ram_a;
  logic [7:0]  ram_d;
  logic [7:0]  ram_dout;
  logic        ram_we_l;
  logic        timeout_p;

  modport master (
    output bus_a, bus_d, bus_memr_l, bus_memw_l, bus_aen, isa_op_enable, vid_a, ram_d,
    input  bus_out_mem, bus_dir_mem, bus_rdy, ram_a, ram_dout, ram_we_l, timeout_p
  );

  modport slave (
    input  bus_a, bus_d, bus_memr_l, bus_memw_l, bus_aen, isa_op_enable, vid_a, ram_d,
    output bus_out_mem, bus_dir_mem, bus_rdy, ram_a, ram_dout, ram_we_l, timeout_p
  );
endinterface

// File: rtl/cga_vram_arbiter.sv
// Arbitrates one pending ISA access to the CGA window against video fetches on single-port VRAM.
// Optional CGA_SNOW_EN: CPU access is issued immediately, overriding video fetches (original snow).
module cga_vram_arbiter #(
  parameter logic [19:0] FRAMEBUFFER_ADDR = 20'hB8000,
  parameter logic [3:0]  RAM_BASE         = 4'b0001,
  parameter logic [7:0]  WAIT_TIMEOUT     = 8'd64
) (
  input logic                 clk,
  input logic                 reset_l,
  cga_vram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PEND, ACCESS, DONE} state_t;

  state_t      state;
  state_t      next_state;

  logic [1:0]  memr_sync;
  logic [1:0]  memw_sync;
  logic        memr_q;
  logic        memw_q;
  logic        memr_s;
  logic        memw_s;
  logic        memr_fall;
  logic        memw_fall;
  logic        decode_hit;
  logic        request;
  logic        timeout_hit;

  logic [14:0] lat_a;
  logic [7:0]  lat_d;
  logic        lat_rd;
  logic [7:0]  rd_data;
  logic        timeout_q;

  logic [18:0] ram_a_c;
  logic        ram_we_l_c;
  logic        bus_rdy_c;
  logic        bus_dir_c;

  // Strobes arrive asynchronously; a third flop gives the edge reference.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      memr_sync <= 2'b11;
      memw_sync <= 2'b11;
      memr_q    <= 1'b1;
      memw_q    <= 1'b1;
    end else begin
      memr_sync <= {memr_sync[0], bus.bus_memr_l};
      memw_sync <= {memw_sync[0], bus.bus_memw_l};
      memr_q    <= memr_sync[1];
      memw_q    <= memw_sync[1];
    end
  end

  assign memr_s     = memr_sync[1];
  assign memw_s     = memw_sync[1];
  assign memr_fall  = memr_q & ~memr_s;
  assign memw_fall  = memw_q & ~memw_s;
  assign decode_hit = (bus.bus_a[19:15] == FRAMEBUFFER_ADDR[19:15]);
  // A strobe edge only counts while the other strobe is idle, so both-low is never taken.
  assign request    = decode_hit & ~bus.bus_aen &
                      ((memr_fall & memw_s) | (memw_fall & memr_s));

`ifdef CGA_SNOW_EN
  assign timeout_hit = 1'b0;
`else
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == PEND) && !bus.isa_op_enable && (wait_cnt == WAIT_TIMEOUT);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wait_cnt <= 8'd0;
    end else if (state == PEND) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (request) next_state = PEND;
`ifdef CGA_SNOW_EN
      PEND:    next_state = ACCESS;
`else
      PEND: begin
        if (bus.isa_op_enable) begin
          next_state = ACCESS;
        end else if (wait_cnt == WAIT_TIMEOUT) begin
          next_state = DONE;
        end
      end
`endif
      ACCESS:  next_state = DONE;
      DONE:    if (memr_s && memw_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture and read-data return; bus_out_mem only changes when a read completes.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      lat_a     <= 15'd0;
      lat_d     <= 8'h00;
      lat_rd    <= 1'b0;
      rd_data   <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state == IDLE && request) begin
        lat_a  <= bus.bus_a[14:0];
        lat_d  <= bus.bus_d;
        lat_rd <= memr_fall;
      end
      if (state == ACCESS && lat_rd) begin
        rd_data <= bus.ram_d;
      end else if (timeout_hit && lat_rd) begin
        rd_data <= 8'hFF;
      end
    end
  end

  always_comb begin
    ram_a_c    = {RAM_BASE, bus.vid_a};
    ram_we_l_c = 1'b1;
    bus_rdy_c  = 1'b1;
    bus_dir_c  = 1'b0;
    case (state)
      PEND:   bus_rdy_c = 1'b0;
      ACCESS: begin
        bus_rdy_c  = 1'b0;
        ram_a_c    = {RAM_BASE, lat_a};
        ram_we_l_c = lat_rd;
      end
      DONE:   bus_dir_c = lat_rd & ~memr_s;
      default: ;
    endcase
  end

  assign bus.ram_a       = ram_a_c;
  assign bus.ram_we_l    = ram_we_l_c;
  assign bus.ram_dout    = lat_d;
  assign bus.bus_rdy     = bus_rdy_c;
  assign bus.bus_dir_mem = bus_dir_c;
  assign bus.bus_out_mem = rd_data;
  assign bus.timeout_p   = timeout_q;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed scoreboard bench for cga_vram_arbiter (default build, CGA_SNOW_EN undefined).
module tb_cga_vram_arbiter;

  logic clk = 1'b0;
  logic reset_l = 1'b0;

  cga_vram_arbiter_if bus_if ();

  cga_vram_arbiter dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
    logic        rd;
  } access_t;

  access_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] a, input logic [7:0] d, input logic rd,
                               input logic [7:0] rdata, input logic expect_access);
    access_t e;
    bus_if.bus_a = a;
    bus_if.bus_d = d;
    if (rd) bus_if.bus_memr_l = 1'b0;
    else    bus_if.bus_memw_l = 1'b0;
    if (expect_access) begin
      e.addr = {4'b0001, a[14:0]};
      e.data = rd ? rdata : d;
      e.rd   = rd;
      sb.push_back(e);
    end
  endtask

  task automatic releaseStrobes();
    bus_if.bus_memr_l = 1'b1;
    bus_if.bus_memw_l = 1'b1;
  endtask

  task automatic pulseSlot();
    bus_if.isa_op_enable = 1'b1;
    tick();
    bus_if.isa_op_enable = 1'b0;
  endtask

  task automatic waitRdyLow(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (bus_if.bus_rdy === 1'b0) break;
      tick();
    end
    checkOutput(tag, bus_if.bus_rdy, 0);
  endtask

  task automatic checkAccess(input string tag, output access_t e);
    e = '{addr: 19'h0, data: 8'h00, rd: 1'b0};
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s: observed empty scoreboard expected pending access", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_ram_a"}, bus_if.ram_a, e.addr);
      checkOutput({tag, "_we_l"}, bus_if.ram_we_l, e.rd ? 1 : 0);
      if (!e.rd) checkOutput({tag, "_dout"}, bus_if.ram_dout, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    access_t e;
    int n;

    bus_if.bus_a = 20'h0;
    bus_if.bus_d = 8'h00;
    bus_if.bus_memr_l = 1'b1;
    bus_if.bus_memw_l = 1'b1;
    bus_if.bus_aen = 1'b0;
    bus_if.isa_op_enable = 1'b0;
    bus_if.vid_a = 15'h1234;
    bus_if.ram_d = 8'hC3;

    // Reset values and the combinational video path.
    tick();
    tick();
    checkOutput("rst_rdy", bus_if.bus_rdy, 1);
    checkOutput("rst_dir", bus_if.bus_dir_mem, 0);
    checkOutput("rst_out", bus_if.bus_out_mem, 8'h00);
    checkOutput("rst_we_l", bus_if.ram_we_l, 1);
    checkOutput("rst_dout", bus_if.ram_dout, 8'h00);
    checkOutput("rst_timeout", bus_if.timeout_p, 0);
    reset_l = 1'b1;
    tick();
    checkOutput("vid_ram_a", bus_if.ram_a, 19'h09234);
    bus_if.vid_a = 15'h7ABC;
    #1;
    checkOutput("vid_ram_a_comb", bus_if.ram_a, 19'h0FABC);

    // Write B8123=5A, slot arrives 5 clk later.
    applyStimulus(20'hB8123, 8'h5A, 1'b0, 8'h00, 1'b1);
    waitRdyLow("wr_rdy_low");
    for (int i = 0; i < 5; i++) tick();
    checkOutput("wr_pend_we_l", bus_if.ram_we_l, 1);
    checkOutput("wr_pend_ram_a", bus_if.ram_a, 19'h0FABC);
    pulseSlot();
    checkAccess("wr", e);
    checkOutput("wr_access_rdy", bus_if.bus_rdy, 0);
    tick();
    checkOutput("wr_done_rdy", bus_if.bus_rdy, 1);
    checkOutput("wr_done_we_l", bus_if.ram_we_l, 1);
    checkOutput("wr_done_dir", bus_if.bus_dir_mem, 0);
    releaseStrobes();
    for (int i = 0; i < 3; i++) tick();

    // Read BBFFF with ram_d=C3 in the slot.
    bus_if.vid_a = 15'h1234;
    applyStimulus(20'hBBFFF, 8'h00, 1'b1, 8'hC3, 1'b1);
    waitRdyLow("rd_rdy_low");
    tick();
    tick();
    checkOutput("rd_pend_ram_a", bus_if.ram_a, 19'h09234);
    pulseSlot();
    checkAccess("rd", e);
    tick();
    checkOutput("rd_out", bus_if.bus_out_mem, e.data);
    checkOutput("rd_dir", bus_if.bus_dir_mem, 1);
    checkOutput("rd_done_rdy", bus_if.bus_rdy, 1);
    checkOutput("rd_done_ram_a", bus_if.ram_a, 19'h09234);
    bus_if.ram_d = 8'h77;
    bus_if.bus_memr_l = 1'b1;
    tick();
    checkOutput("rd_dir_sync_hold", bus_if.bus_dir_mem, 1);
    tick();
    tick();
    checkOutput("rd_dir_release", bus_if.bus_dir_mem, 0);
    checkOutput("rd_out_hold", bus_if.bus_out_mem, 8'hC3);
    tick();

    // Decode miss, DMA cycle and both strobes low are all ignored.
    applyStimulus(20'hB0000, 8'h11, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("miss_rdy", bus_if.bus_rdy, 1);
    pulseSlot();
    checkOutput("miss_we_l", bus_if.ram_we_l, 1);
    releaseStrobes();
    for (int i = 0; i < 3; i++) tick();

    bus_if.bus_aen = 1'b1;
    applyStimulus(20'hB8000, 8'h22, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("aen_rdy", bus_if.bus_rdy, 1);
    pulseSlot();
    checkOutput("aen_we_l", bus_if.ram_we_l, 1);
    releaseStrobes();
    bus_if.bus_aen = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    bus_if.bus_a = 20'hB8004;
    bus_if.bus_memr_l = 1'b0;
    bus_if.bus_memw_l = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("both_rdy", bus_if.bus_rdy, 1);
    releaseStrobes();
    for (int i = 0; i < 3; i++) tick();

    // Read with no slot is abandoned after the wait limit.
    applyStimulus(20'hB8010, 8'h00, 1'b1, 8'h00, 1'b0);
    waitRdyLow("to_rdy_low");
    n = 0;
    while (bus_if.timeout_p !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("to_latency_ok", (n >= 64 && n <= 66) ? 1 : 0, 1);
    checkOutput("to_out", bus_if.bus_out_mem, 8'hFF);
    checkOutput("to_rdy", bus_if.bus_rdy, 1);
    checkOutput("to_we_l", bus_if.ram_we_l, 1);
    tick();
    checkOutput("to_pulse_end", bus_if.timeout_p, 0);
    releaseStrobes();
    for (int i = 0; i < 3; i++) tick();

    // Reset in the middle of a write cycle.
    applyStimulus(20'hB8200, 8'hA5, 1'b0, 8'h00, 1'b1);
    waitRdyLow("mid_rdy_low");
    pulseSlot();
    checkAccess("mid", e);
    reset_l = 1'b0;
    #1;
    checkOutput("mid_rst_we_l", bus_if.ram_we_l, 1);
    checkOutput("mid_rst_rdy", bus_if.bus_rdy, 1);
    releaseStrobes();
    tick();
    tick();
    reset_l = 1'b1;
    tick();
    checkOutput("post_rst_rdy", bus_if.bus_rdy, 1);
    checkOutput("post_rst_we_l", bus_if.ram_we_l, 1);

    applyStimulus(20'hB8001, 8'h3C, 1'b0, 8'h00, 1'b1);
    waitRdyLow("post_rdy_low");
    pulseSlot();
    checkAccess("post", e);
    tick();
    checkOutput("post_done_rdy", bus_if.bus_rdy, 1);
    releaseStrobes();
    for (int i = 0; i < 3; i++) tick();

    checkOutput("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
